// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory request and a one-entry holding register
// toward decode. Branch redirects flush the held instruction or drain a request in flight.
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        Clock,
   input  logic        ResetN,
   output logic        IMemReq,
   output logic [15:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [15:0] IMemData,
   input  logic        BranchTaken,
   input  logic [15:0] BranchTarget,
   input  logic        InstrReady,
   output logic        InstrValid,
   output logic [15:0] Instruction,
   output logic [3:0]  OPCODE,
   output logic [15:0] InstrPC
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] fetch_addr_q, fetch_addr_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;

   logic [15:0] redirect_addr;
   logic        unused_bits;

   // Instructions are halfword aligned, so the target LSB is dropped.
   assign redirect_addr = {BranchTarget[15:1], 1'b0};
   assign unused_bits   = BranchTarget[0];

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         instr_q      <= 16'h0000;
         instr_pc_q   <= 16'h0000;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         instr_q      <= instr_d;
         instr_pc_q   <= instr_pc_d;
         valid_q      <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      valid_d      = valid_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (BranchTaken) begin
               pc_d         = redirect_addr;
               fetch_addr_d = redirect_addr;
               valid_d      = 1'b0;
               instr_d      = 16'h0000;
            end else begin
               fetch_addr_d = pc_q;
            end
         end

         FETCH: begin
            if (IMemAck && BranchTaken) begin
               pc_d         = redirect_addr;
               fetch_addr_d = redirect_addr;
            end else if (IMemAck) begin
               instr_d    = IMemData;
               instr_pc_d = fetch_addr_q;
               valid_d    = 1'b1;
               pc_d       = fetch_addr_q + 16'd2;
               state_d    = HOLD;
            end else if (BranchTaken) begin
               // Request cannot be withdrawn; remember the target and drain it.
               pc_d    = redirect_addr;
               state_d = DRAIN;
            end
         end

         HOLD: begin
            if (BranchTaken) begin
               pc_d         = redirect_addr;
               fetch_addr_d = redirect_addr;
               valid_d      = 1'b0;
               instr_d      = 16'h0000;
               state_d      = FETCH;
            end else if (InstrReady) begin
               valid_d      = 1'b0;
               fetch_addr_d = pc_q;
               state_d      = FETCH;
            end
         end

         DRAIN: begin
            if (BranchTaken) begin
               pc_d = redirect_addr;
            end
            if (IMemAck) begin
               fetch_addr_d = BranchTaken ? redirect_addr : pc_q;
               state_d      = FETCH;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign IMemReq     = (state_q == FETCH) || (state_q == DRAIN);
   assign IMemAddr    = fetch_addr_q;
   assign InstrValid  = valid_q;
   assign Instruction = instr_q;
   assign InstrPC     = instr_pc_q;
   assign OPCODE      = instr_q[15:12];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: inputs change and outputs are checked on the
// falling edge, so each step() is one rising edge of DUT activity.
module tb_instruction_fetch;

   localparam logic [15:0] RST = 16'h0200;

   logic        Clock;
   logic        ResetN;
   logic        IMemReq;
   logic [15:0] IMemAddr;
   logic        IMemAck;
   logic [15:0] IMemData;
   logic        BranchTaken;
   logic [15:0] BranchTarget;
   logic        InstrReady;
   logic        InstrValid;
   logic [15:0] Instruction;
   logic [3:0]  OPCODE;
   logic [15:0] InstrPC;

   int checks_total = 0;
   int checks_pass  = 0;

   instruction_fetch #(.RESET_PC(RST)) dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .IMemReq     (IMemReq),
      .IMemAddr    (IMemAddr),
      .IMemAck     (IMemAck),
      .IMemData    (IMemData),
      .BranchTaken (BranchTaken),
      .BranchTarget(BranchTarget),
      .InstrReady  (InstrReady),
      .InstrValid  (InstrValid),
      .Instruction (Instruction),
      .OPCODE      (OPCODE),
      .InstrPC     (InstrPC)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks_total++;
      if (got === exp) begin
         checks_pass++;
         $display("check %-14s got %h", tag, got);
      end else begin
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Checks the held-instruction outputs in one go.
   task automatic chk_hold(input string tag, input logic [15:0] ins, input logic [15:0] pc);
      chk({tag, "_valid"}, {15'd0, InstrValid}, 16'd1);
      chk({tag, "_instr"}, Instruction, ins);
      chk({tag, "_opc"}, {12'd0, OPCODE}, {12'd0, ins[15:12]});
      chk({tag, "_ipc"}, InstrPC, pc);
      chk({tag, "_req"}, {15'd0, IMemReq}, 16'd0);
   endtask

   task automatic chk_fetch(input string tag, input logic [15:0] addr);
      chk({tag, "_req"}, {15'd0, IMemReq}, 16'd1);
      chk({tag, "_addr"}, IMemAddr, addr);
      chk({tag, "_valid"}, {15'd0, InstrValid}, 16'd0);
   endtask

   initial begin
      ResetN = 1'b0; IMemAck = 1'b1; IMemData = 16'hDEAD;
      BranchTaken = 1'b0; BranchTarget = 16'h0000; InstrReady = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      chk("rst_req", {15'd0, IMemReq}, 16'd0);
      chk("rst_valid", {15'd0, InstrValid}, 16'd0);
      chk("rst_instr", Instruction, 16'h0000);
      chk("rst_ipc", InstrPC, 16'h0000);
      chk("rst_addr", IMemAddr, RST);

      // Zero-wait memory, decode always ready; ack during IDLE must be ignored.
      ResetN = 1'b1; IMemAck = 1'b1; IMemData = 16'h1234; InstrReady = 1'b1;
      step(); chk_fetch("zw_f0", RST);
      step(); chk_hold("zw_h0", 16'h1234, RST);
      IMemData = 16'h2ABC;
      step(); chk_fetch("zw_f1", RST + 16'd2);
      step(); chk_hold("zw_h1", 16'h2ABC, RST + 16'd2);
      IMemData = 16'h3F00;
      step(); chk_fetch("zw_f2", RST + 16'd4);
      step(); chk_hold("zw_h2", 16'h3F00, RST + 16'd4);

      // Decode stalls four cycles, then memory answers after three wait cycles.
      InstrReady = 1'b0; IMemAck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); chk_hold("stall", 16'h3F00, RST + 16'd4);
      end
      InstrReady = 1'b1;
      step(); chk_fetch("wt_f", RST + 16'd6);
      InstrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_fetch("wait", RST + 16'd6);
      end
      IMemAck = 1'b1; IMemData = 16'h4567;
      step(); chk_hold("wt_h", 16'h4567, RST + 16'd6);

      // Redirect in HOLD beats a simultaneous handoff; odd target is aligned.
      IMemAck = 1'b0; InstrReady = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'h0041;
      step(); chk_fetch("brh_f", 16'h0040);
      chk("brh_flush", Instruction, 16'h0000);
      BranchTaken = 1'b0; IMemAck = 1'b1; IMemData = 16'h5040;
      step(); chk_hold("brh_h", 16'h5040, 16'h0040);

      // Redirect during a waiting fetch: drain the old request, discard its data.
      IMemAck = 1'b0; InstrReady = 1'b1;
      step(); chk_fetch("dr_f", 16'h0042);
      BranchTaken = 1'b1; BranchTarget = 16'h0100;
      step(); chk_fetch("dr_d0", 16'h0042);
      BranchTaken = 1'b0;
      step(); chk_fetch("dr_d1", 16'h0042);
      IMemAck = 1'b1; IMemData = 16'hF123;
      step(); chk_fetch("dr_nf", 16'h0100);
      chk("dr_keep", Instruction, 16'h5040);
      IMemData = 16'h6100;
      step(); chk_hold("dr_h", 16'h6100, 16'h0100);

      // Redirect coincident with ack: data dropped, refetch at target; then wrap.
      IMemAck = 1'b0; InstrReady = 1'b1;
      step(); chk_fetch("ba_f", 16'h0102);
      IMemAck = 1'b1; IMemData = 16'h7777; BranchTaken = 1'b1; BranchTarget = 16'hFFFF;
      step(); chk_fetch("ba_nf", 16'hFFFE);
      BranchTaken = 1'b0; IMemData = 16'h8888;
      step(); chk_hold("wrap_h", 16'h8888, 16'hFFFE);
      IMemAck = 1'b0; InstrReady = 1'b1;
      step(); chk_fetch("wrap_f", 16'h0000);

      // Asynchronous reset mid-FETCH, with an ack arriving while reset is held.
      #2 ResetN = 1'b0;
      #1;
      chk("ar_req", {15'd0, IMemReq}, 16'd0);
      chk("ar_valid", {15'd0, InstrValid}, 16'd0);
      chk("ar_instr", Instruction, 16'h0000);
      chk("ar_ipc", InstrPC, 16'h0000);
      chk("ar_addr", IMemAddr, RST);
      IMemAck = 1'b1; IMemData = 16'h9999;
      step();
      chk("ar_held", Instruction, 16'h0000);
      ResetN = 1'b1;
      step(); chk_fetch("ar_f", RST);
      IMemAck = 1'b0;
      step(); chk_fetch("ar_f2", RST);

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
